// File: rtl/flt2int_if.sv
// Host handshake and byte-wide data-memory bus for the float-to-integer converter.
// The core takes the master side; host and memory take the slave side.
interface flt2int_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;

  modport master (
    input  start,
    input  mem_rd_data,
    output done,
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data
  );

  modport slave (
    output start,
    output mem_rd_data,
    input  done,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data
  );
endinterface

// File: rtl/flt2int_core.sv
// Converts a 16-bit float in data memory to a 16-bit two's-complement integer,
// truncating toward zero and saturating out-of-range values.
module flt2int_core #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned SRC_ADDR = 0,
  parameter int unsigned DST_ADDR = 2,
  parameter int unsigned BIAS     = 15
) (
  input logic       clk,
  input logic       reset,
  flt2int_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StRdLo, StRdHi, StClass, StAlign, StNeg, StWrLo, StWrHi, StDone
  } state_e;

  state_e            state_q;
  logic              armed_q;
  logic              done_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        lo_q;
  logic [7:0]        hi_q;
  logic [15:0]       w_q;
  logic [3:0]        cnt_q;
  logic              shr_q;

  logic              sign;
  logic [4:0]        exp_f;
  logic [9:0]        man;
  logic signed [7:0] e;
  logic              is_zero;
  logic              is_norm;
  logic [3:0]        shamt;
  logic [15:0]       sat_val;
  logic [15:0]       w_neg;

  always_comb begin
    sign    = hi_q[7];
    exp_f   = hi_q[6:2];
    man     = {hi_q[1:0], lo_q};
    e       = $signed({3'b000, exp_f}) - $signed(8'(BIAS));
    is_zero = (exp_f == 5'd0) || (e < 8'sd0);
    // e=15 and exp=31 both saturate, even if BIAS would allow a larger e.
    is_norm = !is_zero && (e <= 8'sd14) && (exp_f != 5'd31);
    shamt   = (e < 8'sd10) ? 4'(8'sd10 - e) : 4'(e - 8'sd10);
    sat_val = sign ? 16'h8000 : 16'h7FFF;
    w_neg   = sign ? (~w_q + 16'd1) : w_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      w_q       <= '0;
      cnt_q     <= '0;
      shr_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // Leave only on the first start=0 edge following a start=1 edge.
          if (bus.start) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q <= 1'b0;
            addr_q  <= ADDR_W'(SRC_ADDR);
            state_q <= StRdLo;
          end
        end
        StRdLo: begin
          lo_q    <= bus.mem_rd_data;
          addr_q  <= ADDR_W'(SRC_ADDR + 1);
          state_q <= StRdHi;
        end
        StRdHi: begin
          hi_q    <= bus.mem_rd_data;
          addr_q  <= '0;
          state_q <= StClass;
        end
        StClass: begin
          if (is_norm) begin
            w_q     <= {5'b00000, 1'b1, man};
            cnt_q   <= shamt;
            shr_q   <= (e < 8'sd10);
            state_q <= (e == 8'sd10) ? StNeg : StAlign;
          end else begin
            w_q       <= is_zero ? 16'h0000 : sat_val;
            wr_en_q   <= 1'b1;
            addr_q    <= ADDR_W'(DST_ADDR);
            wr_data_q <= is_zero ? 8'h00 : sat_val[7:0];
            state_q   <= StWrLo;
          end
        end
        StAlign: begin
          w_q   <= shr_q ? (w_q >> 1) : (w_q << 1);
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StNeg;
          end
        end
        StNeg: begin
          w_q       <= w_neg;
          wr_en_q   <= 1'b1;
          addr_q    <= ADDR_W'(DST_ADDR);
          wr_data_q <= w_neg[7:0];
          state_q   <= StWrLo;
        end
        StWrLo: begin
          addr_q    <= ADDR_W'(DST_ADDR + 1);
          wr_data_q <= w_q[15:8];
          state_q   <= StWrHi;
        end
        StWrHi: begin
          wr_en_q   <= 1'b0;
          addr_q    <= '0;
          wr_data_q <= '0;
          done_q    <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (bus.start) begin
            done_q  <= 1'b0;
            armed_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.done        = done_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wr_data_q;

endmodule
